// File: rtl/or_circuit_capture.sv
// or_circuit_capture
//
// Capture stage for the five outputs of the upstream gate network.
// It watches obs = {t, n, r, k, m}. When armed, it records a baseline
// sample stamped ts = 0, then records {ts, obs} each time the vector
// changes inside a programmable window. Records wait in a small FIFO
// that is drained over a valid/ready port. When the FIFO is full and
// no pop happens in the same cycle, the record is dropped and counted.
// Sampling never stalls.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle arm pulse, honoured in IDLE only
//   abort        cancel the capture, honoured in RUN and DRAIN
//   win_len      window length in cycles, latched on start (0 -> 1)
//   t,n,r,k,m    gate-network outputs, obs = {t,n,r,k,m}
//   rec_valid    FIFO head valid
//   rec_ready    consumer accepts the head when rec_valid is also high
//   rec_data     {ts, t, n, r, k, m} of the FIFO head, 0 when not valid
//   busy         capture in progress (state is not IDLE)
//   done         one-cycle pulse: window closed and FIFO drained
//   drop_cnt     records lost to a full FIFO, saturates at 255
//   overflow     sticky flag, set on the first drop
//
// State table
//   IDLE  | waiting for start; FIFO empty
//   RUN   | sampling window open; baseline push, then pushes on change
//   DRAIN | window closed; waiting for the consumer to empty the FIFO

module or_circuit_capture #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TS_W-1:0]   win_len,
    input  logic              t,
    input  logic              n,
    input  logic              r,
    input  logic              k,
    input  logic              m,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W+4:0]   rec_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        drop_cnt,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [TS_W-1:0]  wl_q, wl_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [4:0]       smp_q;
    logic [4:0]       last_q, last_d;
    logic [7:0]       drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic [TS_W+4:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [4:0] obs;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       start_hit;
    logic       abort_hit;
    logic       flush;
    logic       push_req;
    logic       push_ok;
    logic       push_drop;
    logic       last_run;

    assign obs        = {t, n, r, k, m};
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign pop        = rec_valid && rec_ready;

    assign start_hit  = start && (state_q == ST_IDLE);
    assign abort_hit  = abort && (state_q != ST_IDLE);
    assign flush      = start_hit || abort_hit;

    // The first RUN cycle always pushes the baseline sample. After that, a
    // record is pushed only when the sample differs from the one before.
    // Abort suppresses the push because the FIFO is flushed in that cycle.
    assign push_req   = (state_q == ST_RUN) && !abort &&
                        ((ts_q == '0) || (smp_q != last_q));
    // A pop in the same cycle frees a slot, so the push still fits.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && fifo_full && !pop;

    assign last_run   = (ts_q == (wl_q - TS_W'(1)));

    assign rec_valid  = !fifo_empty;
    assign rec_data   = rec_valid ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DRAIN) && fifo_empty && !abort;
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;

    // ------------------------------------------------------------------
    // FSM, window timer and drop accounting
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        ts_d    = ts_q;
        last_d  = last_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wl_d    = (win_len == '0) ? TS_W'(1) : win_len;
                    ts_d    = '0;
                    drop_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    last_d = smp_q;
                    ts_d   = ts_q + TS_W'(1);
                    if (last_run) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort || fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push_drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wl_q     <= TS_W'(1);
            ts_q     <= '0;
            smp_q    <= '0;
            last_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wl_q     <= wl_d;
            ts_q     <= ts_d;
            smp_q    <= obs;
            last_q   <= last_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through rec_data
    // while the occupancy count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {ts_q, smp_q};
        end
    end

endmodule

// File: tb/tb_or_circuit_capture.sv
module tb_or_circuit_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  win_len;
    logic        t, n, r, k, m;
    logic        rec_valid;
    logic        rec_ready;
    logic [12:0] rec_data;
    logic        busy;
    logic        done;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    or_circuit_capture #(.DEPTH(4), .TS_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .win_len   (win_len),
        .t         (t),
        .n         (n),
        .r         (r),
        .k         (k),
        .m         (m),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .busy      (busy),
        .done      (done),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  wl;
        logic [4:0]  obs;
        logic        rdy;
        logic        exp_valid;
        logic [12:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_obs(input logic [4:0] v);
        {t, n, r, k, m} = v;
    endtask

    function automatic logic [12:0] rec(input int ts, input logic [4:0] o);
        return {8'(ts), o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; win_len = 8'd0;
        rec_ready = 1'b0; set_obs(5'b0);

        // ---------------- reset values ----------------
        #1;
        chk("rst_valid",    32'(rec_valid), 32'd0);
        chk("rst_data",     32'(rec_data),  32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_drop",     32'(drop_cnt),  32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;

        // ---------------- reset mid-capture ----------------
        step(); start = 1'b1; win_len = 8'd20; rec_ready = 1'b0; set_obs(5'b00000);
        for (int j = 1; j <= 6; j++) begin
            step(); start = 1'b0; set_obs({3'b000, j[0], 1'b0});
        end
        #1;
        chk("rm_pre_drop",  32'(drop_cnt),  32'd1);
        chk("rm_pre_ovf",   32'(overflow),  32'd1);
        chk("rm_pre_valid", 32'(rec_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(rec_valid), 32'd0);
        chk("rm_busy",  32'(busy),      32'd0);
        chk("rm_drop",  32'(drop_cnt),  32'd0);
        chk("rm_ovf",   32'(overflow),  32'd0);
        chk("rm_data",  32'(rec_data),  32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        step(); #1;
        chk("rm_idle_busy",  32'(busy),      32'd0);
        chk("rm_idle_valid", 32'(rec_valid), 32'd0);

        // ---------------- baseline plus single change (table) ----------------
        tbl[0]  = '{1'b1, 8'd10, 5'b00000, 1'b1, 1'b0, 13'h000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd10, 5'b00000, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'd10, 5'b00000, 1'b1, 1'b1, 13'h000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b1, 13'h061, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'd10, 5'b00001, 1'b1, 1'b0, 13'h000, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            step();
            start = tbl[i].start; win_len = tbl[i].wl;
            set_obs(tbl[i].obs); rec_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(rec_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i),  32'(rec_data),  32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_done", i),  32'(done),      32'(tbl[i].exp_done));
        end
        start = 1'b0;

        // ---------------- overflow ----------------
        step(); start = 1'b1; win_len = 8'd8; rec_ready = 1'b0; set_obs(5'b00000);
        for (int j = 1; j <= 8; j++) begin
            step(); start = 1'b0; set_obs({3'b000, j[0], 1'b0});
        end
        step(); #1;
        chk("ov_drop",  32'(drop_cnt),  32'd4);
        chk("ov_ovf",   32'(overflow),  32'd1);
        chk("ov_valid", 32'(rec_valid), 32'd1);
        chk("ov_busy",  32'(busy),      32'd1);
        chk("ov_hold_done0", 32'(done), 32'd0);
        step(); #1;
        chk("ov_hold_done1", 32'(done), 32'd0);
        chk("ov_hold_head",  32'(rec_data), 32'(rec(0, 5'b00000)));
        for (int i = 0; i < 4; i++) begin
            step(); rec_ready = 1'b1; #1;
            chk($sformatf("ov_pop%0d_data", i), 32'(rec_data),
                32'(rec(i, {3'b000, i[0], 1'b0})));
            chk($sformatf("ov_pop%0d_done", i), 32'(done), 32'd0);
        end
        step(); #1;
        chk("ov_end_valid", 32'(rec_valid), 32'd0);
        chk("ov_end_done",  32'(done),      32'd1);
        chk("ov_end_drop",  32'(drop_cnt),  32'd4);
        step(); #1;
        chk("ov_idle_busy", 32'(busy), 32'd0);
        chk("ov_idle_done", 32'(done), 32'd0);
        rec_ready = 1'b0;

        // ---------------- full with simultaneous pop and push ----------------
        step(); start = 1'b1; win_len = 8'd12; rec_ready = 1'b0; set_obs(5'b00000);
        for (int j = 1; j <= 3; j++) begin
            step(); start = 1'b0; set_obs({3'b000, j[0], 1'b0});
        end
        step(); set_obs(5'b00010);
        step(); set_obs(5'b00010);
        step(); set_obs(5'b00000);
        step(); rec_ready = 1'b1; #1;
        chk("fp_head0", 32'(rec_data), 32'(rec(0, 5'b00000)));
        chk("fp_drop_before", 32'(drop_cnt), 32'd0);
        step(); #1;
        chk("fp_drop_after", 32'(drop_cnt), 32'd0);
        chk("fp_ovf_after",  32'(overflow), 32'd0);
        chk("fp_rec1", 32'(rec_data), 32'(rec(1, 5'b00010)));
        step(); #1; chk("fp_rec2", 32'(rec_data), 32'(rec(2, 5'b00000)));
        step(); #1; chk("fp_rec3", 32'(rec_data), 32'(rec(3, 5'b00010)));
        step(); #1; chk("fp_rec6", 32'(rec_data), 32'(rec(6, 5'b00000)));
        step(); #1;
        chk("fp_empty_valid", 32'(rec_valid), 32'd0);
        chk("fp_last_run_busy", 32'(busy), 32'd1);
        chk("fp_last_run_done", 32'(done), 32'd0);
        step(); #1; chk("fp_done", 32'(done), 32'd1);
        step(); #1; chk("fp_idle", 32'(busy), 32'd0);
        rec_ready = 1'b0;

        // ---------------- abort in DRAIN ----------------
        step(); start = 1'b1; win_len = 8'd3; rec_ready = 1'b0; set_obs(5'b00000);
        for (int j = 1; j <= 3; j++) begin
            step(); start = 1'b0; set_obs({3'b000, j[0], 1'b0});
        end
        step(); #1;
        chk("ab_drain_busy",  32'(busy),      32'd1);
        chk("ab_drain_valid", 32'(rec_valid), 32'd1);
        abort = 1'b1; #1;
        chk("ab_abort_done", 32'(done), 32'd0);
        step(); abort = 1'b0; #1;
        chk("ab_valid", 32'(rec_valid), 32'd0);
        chk("ab_busy",  32'(busy),      32'd0);
        chk("ab_data",  32'(rec_data),  32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk($sformatf("ab_no_done%0d", i), 32'(done), 32'd0);
        end

        // ---------------- ignored start, then win_len = 0 ----------------
        step(); start = 1'b1; win_len = 8'd4; rec_ready = 1'b1; set_obs(5'b10101);
        step(); start = 1'b0;
        step(); start = 1'b1; win_len = 8'd0; #1;
        chk("is_rec0_valid", 32'(rec_valid), 32'd1);
        chk("is_rec0_data",  32'(rec_data),  32'(rec(0, 5'b10101)));
        step(); start = 1'b0; #1;
        chk("is_valid_after", 32'(rec_valid), 32'd0);
        step(); #1;
        chk("is_last_run_busy", 32'(busy), 32'd1);
        chk("is_last_run_done", 32'(done), 32'd0);
        step(); #1;
        chk("is_done", 32'(done), 32'd1);
        step(); #1;
        chk("is_idle", 32'(busy), 32'd0);
        start = 1'b1; win_len = 8'd0;
        step(); start = 1'b0; set_obs(5'b01010); #1;
        chk("w0_run_busy",  32'(busy),      32'd1);
        chk("w0_run_valid", 32'(rec_valid), 32'd0);
        step(); #1;
        chk("w0_drain_busy", 32'(busy),      32'd1);
        chk("w0_rec_valid",  32'(rec_valid), 32'd1);
        chk("w0_rec_data",   32'(rec_data),  32'(rec(0, 5'b10101)));
        chk("w0_drain_done", 32'(done),      32'd0);
        step(); #1;
        chk("w0_no_second", 32'(rec_valid), 32'd0);
        chk("w0_done",      32'(done),      32'd1);
        step(); #1;
        chk("w0_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or_circuit_capture.md
# or_circuit_capture

Capture stage that sits directly downstream of the combinational gate network and consumes its five outputs t, n, r, k and m. When armed, it records a timestamped baseline sample, then one record for every change of the 5-bit output vector within a programmable window. Records are buffered in a small FIFO and drained over a valid/ready interface. Overflow is counted, never stalls sampling, and the block pulses done once the window has closed and the FIFO has drained.

## Interface
- DEPTH, 4: FIFO entries, power of two, minimum 2.
- TS_W, 8: timestamp and window-length width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle arm pulse; honoured only in IDLE.
- abort  in  1  cancels a capture; honoured in RUN and DRAIN.
- win_len  in  TS_W  window length in cycles, sampled on start; 0 is treated as 1.
- t, n, r, k, m  in  1 each  outputs of the gate network; vector order obs = {t,n,r,k,m}.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer accepts the head when valid and ready are both high.
- rec_data  out  TS_W+5  {ts, t, n, r, k, m} of the FIFO head.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at capture completion.
- drop_cnt  out  8  records lost to a full FIFO; saturates at 255.
- overflow  out  1  sticky; set on the first drop.

## Operation
- Input register: smp <= obs every cycle, in all states. last holds the previously seen smp.
- States:
  - IDLE: start=1 latches win_len (0 becomes 1) into wl, clears ts, drop_cnt and overflow, and flushes the FIFO; next state RUN.
  - RUN: in the first RUN cycle (ts=0) a {0, smp} record is pushed unconditionally.
    - In later RUN cycles a {ts, smp} record is pushed only when smp != last.
    - last <= smp every RUN cycle.
    - ts increments each RUN cycle; the cycle with ts == wl-1 is the last RUN cycle, then next state DRAIN.
  - DRAIN: no pushes. When the FIFO is empty, done=1 for that cycle and next state IDLE.
  - abort in RUN or DRAIN: next state IDLE, FIFO flushed, no done. abort takes priority over all other transitions in that cycle.
- start outside IDLE is ignored. abort in IDLE is ignored.
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the record is discarded, drop_cnt increments (saturating) and overflow is set.
- Push into an empty FIFO: there is no bypass. rec_valid rises the following cycle.
- Pop: when rec_valid and rec_ready are both high, the head advances at the clock edge. rec_data is stable while rec_valid is high and rec_ready is low.
- rec_data is 0 whenever rec_valid is 0.

## Timing
- Reset values, applied immediately on rst_n low: state IDLE, rec_valid 0, rec_data 0, busy 0, done 0, drop_cnt 0, overflow 0, FIFO empty, ts 0, smp 0, last 0.
- Reset mid-operation discards all records.
- Latency:
  - An obs change in cycle c appears in smp at cycle c+1.
  - It is pushed at the end of cycle c+1, with ts equal to the ts value in cycle c+1.
  - With an empty FIFO, rec_valid is high in cycle c+2.
- Cycle counts:
  - busy rises the cycle after start.
  - RUN lasts exactly wl cycles.
  - With rec_ready held high, done is at the earliest one cycle after the last pop.
- ts wraps are impossible because wl ≤ 2^TS_W − 1.

## Test plan
- Reset mid-capture:
  - Stimulus: start with win_len=20, hold rec_ready=0, assert rst_n=0 at ts=5.
  - Required: rec_valid, busy, drop_cnt and overflow read 0 with no clock edge; after release, the state is IDLE.
- Baseline plus single change:
  - Stimulus: obs=5'b00000, win_len=10, rec_ready=1. Set m=1 so smp changes in the RUN cycle with ts=3.
  - Required: records {0,00000} then {3,00001}; busy low and done pulsed exactly once after RUN plus the final pop.
- Overflow (DEPTH=4):
  - Stimulus: rec_ready=0, win_len=8, toggle k every cycle.
  - Required: FIFO holds records with ts 0,1,2,3; drop_cnt=4; overflow=1; DRAIN holds until rec_ready=1, then 4 pops, then done.
- Full with simultaneous pop and push:
  - Stimulus: FIFO full, rec_ready=1 in the same cycle a change record is pushed.
  - Required: the push is accepted, drop_cnt is unchanged and occupancy stays 4.
- Abort in DRAIN:
  - Stimulus: 3 records queued, abort=1.
  - Required: next cycle rec_valid=0 and busy=0; done never asserts.
- Ignored start and win_len=0:
  - Stimulus: start pulsed during RUN, then a fresh start with win_len=0.
  - Required: the first capture is unaffected; the second has exactly one RUN cycle and exactly one record {0, smp}.
